// File: rtl/multiplier_seq_if.sv
// Handshake and operand/product bus between the execute control logic and the
// iterative multiplier.
interface multiplier_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signedOp;
  logic             flush;
  logic [WIDTH-1:0] multiplicandIn;
  logic [WIDTH-1:0] multiplierIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] productHi;
  logic [WIDTH-1:0] productLo;

  modport master (
    output start, signedOp, flush, multiplicandIn, multiplierIn,
    input  busy, done, productHi, productLo
  );

  modport slave (
    input  start, signedOp, flush, multiplicandIn, multiplierIn,
    output busy, done, productHi, productLo
  );
endinterface

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, signed
// operands handled by multiplying magnitudes and negating the result.
module multiplier_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  multiplier_seq_if.slave bus
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StIterate,
    StFixup,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic             signed_q, signed_d;
  logic             neg_q, neg_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_fix;

  // Datapath: add the multiplicand when the multiplier LSB (sitting in lo[0]) is set.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    acc     = {hi_q, lo_q};
    acc_fix = neg_q ? -acc : acc;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    signed_d  = signed_q;
    neg_d     = neg_q;

    if (bus.flush && (state_q != StIdle)) begin
      // Abort: product outputs keep whatever the last completed multiply left.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.flush) begin
            a_d      = bus.multiplicandIn;
            b_d      = bus.multiplierIn;
            signed_d = bus.signedOp;
            state_d  = StSetup;
          end
        end

        StSetup: begin
          if (signed_q) begin
            // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
            a_d   = a_q[WIDTH-1] ? -a_q : a_q;
            lo_d  = b_q[WIDTH-1] ? -b_q : b_q;
            neg_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
          end else begin
            a_d   = a_q;
            lo_d  = b_q;
            neg_d = 1'b0;
          end
          hi_d    = '0;
          cnt_d   = '0;
          state_d = StIterate;
        end

        StIterate: begin
          hi_d  = sum[WIDTH:1];
          lo_d  = {sum[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StFixup;
          end
        end

        StFixup: begin
          {hi_d, lo_d}           = acc_fix;
          {prod_hi_d, prod_lo_d} = acc_fix;
          state_d                = StDone;
        end

        StDone: begin
          state_d = StIdle;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      signed_q  <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      signed_q  <= signed_d;
      neg_q     <= neg_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.productHi = prod_hi_q;
  assign bus.productLo = prod_lo_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq: directed vector table, random operands
// against an arithmetic reference, and handshake/flush/reset corner sequences.
module tb_multiplier_seq;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  multiplier_seq_if #(.WIDTH(W)) bus ();

  multiplier_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    return 64'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one multiply and wait for done. restart_at >= 1 raises a second start
  // (different operands) so that it is sampled on that edge while busy.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input int restart_at, output logic [63:0] prod, output int lat,
                     output int busy_cycles);
    @(negedge clk);
    bus.start          = 1'b1;
    bus.signedOp       = s;
    bus.multiplicandIn = a;
    bus.multiplierIn   = b;
    @(posedge clk);
    #1;
    bus.start          = 1'b0;
    bus.signedOp       = ~s;
    bus.multiplicandIn = $urandom;
    bus.multiplierIn   = $urandom;
    lat         = -1;
    prod        = '0;
    busy_cycles = bus.busy ? 1 : 0;
    for (int k = 1; k <= 100; k++) begin
      if (k == restart_at) begin
        bus.start          = 1'b1;
        bus.multiplicandIn = 32'd3;
        bus.multiplierIn   = 32'd9;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        lat  = k;
        prod = {bus.productHi, bus.productLo};
        break;
      end
    end
    @(posedge clk);
    #1;
    check("idle_after_done", {62'b0, bus.busy, bus.done}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] prod;
    logic [63:0] prev;
    logic [63:0] exp;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          lat;
    int          bc;
    int          seen_done;

    vecs[0] = '{32'd7,         32'd6,         1'b0, 64'h00000000_0000002A};
    vecs[1] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFF_FFFFFFF1};
    vecs[2] = '{32'hFFFFFFFD, 32'h00000005, 1'b0, 64'h00000004_FFFFFFF1};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001};
    vecs[7] = '{32'h00000000, 32'h12345678, 1'b1, 64'h00000000_00000000};

    reset              = 1'b0;
    bus.start          = 1'b0;
    bus.signedOp       = 1'b0;
    bus.flush          = 1'b0;
    bus.multiplicandIn = '0;
    bus.multiplierIn   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_done", {63'b0, bus.done}, 64'd0);
    check("reset_product", {bus.productHi, bus.productLo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Flush together with start in IDLE: start must be dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_beats_start", {63'b0, bus.busy}, 64'd0);

    // Consecutive calls also exercise start in the cycle right after done.
    for (int i = 0; i < 8; i++) begin
      run(vecs[i].a, vecs[i].b, vecs[i].s, 0, prod, lat, bc);
      check($sformatf("vec%0d_product", i), prod, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd35);
    end

    for (int i = 0; i < 20; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rs  = 1'($urandom_range(0, 1));
      exp = ref_mul(ra, rb, rs);
      run(ra, rb, rs, 0, prod, lat, bc);
      check($sformatf("rand%0d_product", i), prod, exp);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'd34);
    end

    // Second start while busy is ignored.
    run(32'd1234, 32'd5678, 1'b0, 5, prod, lat, bc);
    check("restart_product", prod, 64'd7006652);
    check("restart_latency", 64'(lat), 64'd34);
    prev = prod;

    // Flush mid-ITERATE: no done, product retained, then a normal multiply.
    @(negedge clk);
    bus.start          = 1'b1;
    bus.signedOp       = 1'b0;
    bus.multiplicandIn = 32'h1111;
    bus.multiplierIn   = 32'h2222;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    seen_done = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done++;
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", {63'b0, bus.busy}, 64'd0);
    repeat (40) begin
      if (bus.done) seen_done++;
      @(posedge clk);
      #1;
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_product_kept", {bus.productHi, bus.productLo}, prev);
    run(32'd2, 32'd3, 1'b0, 0, prod, lat, bc);
    check("after_flush_product", prod, 64'd6);
    check("after_flush_latency", 64'(lat), 64'd34);

    // Asynchronous reset mid-ITERATE clears outputs before any clock edge.
    @(negedge clk);
    bus.start          = 1'b1;
    bus.signedOp       = 1'b1;
    bus.multiplicandIn = 32'hFFFFFFFF;
    bus.multiplierIn   = 32'h7FFFFFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_busy", {63'b0, bus.busy}, 64'd0);
    check("async_reset_done", {63'b0, bus.done}, 64'd0);
    check("async_reset_product", {bus.productHi, bus.productLo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run(32'd0, 32'h12345678, 1'b0, 0, prod, lat, bc);
    check("post_reset_product", prod, 64'd0);
    check("post_reset_latency", 64'(lat), 64'd34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_seq.md
Name: multiplier_seq

Overview:
- Iterative shift-add integer multiplier for the cpu32e2 execute stage.
- Companion to the shift-subtract divider: the divider shifts its dividend left into the remainder, while this block shifts its product right and adds the multiplicand.
- Takes two WIDTH-bit operands, signed or unsigned, and returns a 2*WIDTH-bit product after a fixed latency.
- Uses a start/busy/done handshake toward the execute control logic.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- signedOp  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- flush  input  1  synchronous abort; returns to IDLE, no done.
- multiplicandIn  input  WIDTH  operand A; captured with start.
- multiplierIn  input  WIDTH  operand B; captured with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the product is valid.
- productHi  output  WIDTH  upper half of the product.
- productLo  output  WIDTH  lower half of the product.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, busy=0, done=0, productHi=0, productLo=0, all internal registers=0. Reset mid-operation discards the operation, and no done is produced.
- States: IDLE, SETUP, ITERATE, FIXUP, DONE.
- IDLE: on start=1, capture the operands and signedOp, then go to SETUP. start in any other state is ignored, with no queuing.
- SETUP, 1 cycle:
  - If signedOp, store the magnitudes |A| and |B| and record negResult = A[msb] XOR B[msb]; otherwise store A and B unchanged and set negResult=0.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned WIDTH bits.
  - Load hi=0, lo=|B|, counter=0, then go to ITERATE.
- ITERATE, WIDTH cycles:
  - Compute sum = {1'b0,hi} + (lo[0] ? {1'b0,|A|} : 0), a WIDTH+1-bit value.
  - Then {hi,lo} <= {sum,lo} >> 1, a logical right shift of the (2*WIDTH+1)-bit concatenation.
  - counter increments each cycle; after the iteration with counter==WIDTH-1, go to FIXUP.
- FIXUP, 1 cycle: if negResult, {hi,lo} <= -{hi,lo} (2*WIDTH-bit two's-complement negate); load productHi/productLo; go to DONE.
- DONE, 1 cycle: done=1, then return to IDLE.
- Latency:
  - The edge that samples start is edge 0.
  - done is high in the cycle following edge WIDTH+2 (edge 34 for WIDTH=32).
  - busy is high from after edge 0 through the DONE cycle.
- productHi/productLo hold their value until the next FIXUP or reset. They are not updated during ITERATE; intermediates stay internal.
- flush=1 in any non-IDLE state: next state IDLE, counter=0, done=0; product outputs keep their previous value. flush in IDLE has no effect.
- Simultaneous flush and start in IDLE: flush wins, and start is not accepted.
- Operand inputs may change freely after the start cycle without affecting the result.
- Zero operand: the block runs the full latency; there is no early-out.

Test Plan:
- Unsigned 7 x 6: start with signedOp=0 -> done exactly at edge 34, productHi=0x00000000, productLo=0x0000002A; busy high for 35 cycles.
- Signed -3 x 5 (0xFFFFFFFD, 0x00000005, signedOp=1) -> productHi=0xFFFFFFFF, productLo=0xFFFFFFF1. The same operands with signedOp=0 -> productHi=0x00000004, productLo=0xFFFFFFF1.
- Extremes:
  - unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE_00000001;
  - signed 0x80000000 x 0x80000000 -> 0x40000000_00000000;
  - signed 0x80000000 x 0x00000001 -> 0xFFFFFFFF_80000000.
- Handshake:
  - a second start at cycle 5 while busy, with different operands, is ignored, and the first result is delivered;
  - back-to-back start in the cycle after done is accepted.
- flush at cycle 10 of ITERATE -> busy=0 next cycle, no done pulse, previous product retained; a new 2 x 3 then yields 0x6 at normal latency.
- Assert reset low mid-ITERATE -> all outputs 0 immediately (asynchronously); after release the block is in IDLE, and 0 x 0x12345678 returns 0 with done at edge 34.
